// File: rtl/loop_ctrl_pkg.sv
// Shared definitions for the loop sequencing controller: state codes,
// error-magnitude width, the registered output bundle and small helpers.
package loop_ctrl_pkg;

    localparam int DPD_W   = 19;
    localparam int MAG_W   = 18;
    localparam int ALPHA_W = 3;
    localparam int BETA_W  = 4;

    localparam logic signed [DPD_W-1:0] DPD_MIN = {1'b1, {(DPD_W-1){1'b0}}};
    localparam logic        [MAG_W-1:0] MAG_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_PER_CAL = 3'd2,
        S_ACQ     = 3'd3,
        S_TRACK   = 3'd4,
        S_FAIL    = 3'd5
    } state_t;

    // Which side of the threshold extends the run: below while acquiring,
    // at-or-above while tracking (looking for loss of lock).
    typedef enum logic {
        RUN_BELOW = 1'b0,
        RUN_ABOVE = 1'b1
    } run_mode_t;

    typedef struct packed {
        logic               rst_l_per;
        logic               rst_l_dpd;
        logic               open_loop;
        logic [ALPHA_W-1:0] alpha;
        logic [BETA_W-1:0]  beta;
        logic               locked;
        logic               fail;
    } ctrl_out_t;

    localparam ctrl_out_t CTRL_RST = '{
        rst_l_per: 1'b1, rst_l_dpd: 1'b1, open_loop: 1'b1,
        alpha: '0, beta: '0, locked: 1'b0, fail: 1'b0
    };

    // |v| folded into MAG_W bits; the single unrepresentable value clamps.
    function automatic logic [MAG_W-1:0] abs_sat(input logic signed [DPD_W-1:0] v);
        logic [DPD_W-1:0] neg;
        neg = DPD_W'(-v);
        if (!v[DPD_W-1])
            return v[MAG_W-1:0];
        else if (v == DPD_MIN)
            return MAG_MAX;
        else
            return neg[MAG_W-1:0];
    endfunction

    // Output bundle for a given state; gains follow the live config inputs.
    function automatic ctrl_out_t outs_for(
        input state_t             s,
        input logic [ALPHA_W-1:0] alpha_acq,
        input logic [ALPHA_W-1:0] alpha_trk,
        input logic [BETA_W-1:0]  beta_acq,
        input logic [BETA_W-1:0]  beta_trk
    );
        ctrl_out_t o;
        o = '{rst_l_per: 1'b1, rst_l_dpd: 1'b1, open_loop: 1'b1,
              alpha: alpha_acq, beta: beta_acq, locked: 1'b0, fail: 1'b0};
        case (s)
            S_PER_CAL: o.rst_l_per = 1'b0;
            S_ACQ: begin
                o.rst_l_dpd = 1'b0;
                o.open_loop = 1'b0;
            end
            S_TRACK: begin
                o.rst_l_dpd = 1'b0;
                o.open_loop = 1'b0;
                o.alpha     = alpha_trk;
                o.beta      = beta_trk;
                o.locked    = 1'b1;
            end
            S_FAIL: begin
                o.rst_l_per = 1'b0;
                o.fail      = 1'b1;
            end
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/loop_seq_ctrl_if.sv
// Control/status bundle between the loop sequencer and its environment:
// requests and phase error in, loop-control and status flags out.
interface loop_seq_ctrl_if;
    import loop_ctrl_pkg::*;

    logic                     start;
    logic                     abort;
    logic signed [DPD_W-1:0]  dpd_out;

    logic                     rst_l_per;
    logic                     rst_l_dpd;
    logic                     openLoop;
    logic [ALPHA_W-1:0]       alpha;
    logic [BETA_W-1:0]        beta;
    logic                     locked;
    logic                     fail;
    logic                     unlock_evt;
    logic [2:0]               state;

    modport master (
        output start, abort, dpd_out,
        input  rst_l_per, rst_l_dpd, openLoop, alpha, beta,
               locked, fail, unlock_evt, state
    );

    modport slave (
        input  start, abort, dpd_out,
        output rst_l_per, rst_l_dpd, openLoop, alpha, beta,
               locked, fail, unlock_evt, state
    );

endinterface

// File: rtl/err_run_cnt.sv
// Phase-error magnitude and consecutive-cycle run counter. The run extends
// while the magnitude is on the selected side of the threshold and restarts
// otherwise; hit flags that this cycle's update reaches the run target.
module err_run_cnt
    import loop_ctrl_pkg::*;
#(
    parameter int LCK_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  run_mode_t               mode,
    input  logic [MAG_W-1:0]        thr,
    input  logic [LCK_W-1:0]        lock_cnt,
    input  logic signed [DPD_W-1:0] dpd_out,
    output logic                    hit
);

    logic [MAG_W-1:0] mag;
    logic             in_run;
    logic [LCK_W-1:0] run_q;
    logic [LCK_W-1:0] run_inc;
    logic [LCK_W-1:0] target;

    // Next run value and target comparison; hit is taken from the updated
    // value so a run of N cycles is acted on at the end of the N-th cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
        run_inc = '0;
        mag     = abs_sat(dpd_out);
        in_run  = (mode == RUN_BELOW) ? (mag < thr) : (mag >= thr);
        target  = (lock_cnt == '0) ? LCK_W'(1) : lock_cnt;
        if (in_run)
            run_inc = (run_q == '1) ? run_q : run_q + 1'b1;
        hit = (run_inc == target);
    end

    // Run counter register, cleared whenever the sequencer changes state.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst)
            run_q <= '0;
        else if (clear)
            run_q <= '0;
        else
            run_q <= run_inc;
    end

endmodule

// File: rtl/loop_seq_ctrl.sv
// Acquisition/tracking sequencer for a DLL/PLL loop: period-estimator
// settling, acquisition with timeout, lock tracking with unlock detection.
// All outputs are registered and describe the state being entered.
module loop_seq_ctrl
    import loop_ctrl_pkg::*;
#(
    parameter int TMR_W = 16,
    parameter int LCK_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    loop_seq_ctrl_if.slave     bus,
    input  logic [TMR_W-1:0]   per_settle,
    input  logic [TMR_W-1:0]   acq_timeout,
    input  logic [MAG_W-1:0]   lock_thr,
    input  logic [MAG_W-1:0]   unlock_thr,
    input  logic [LCK_W-1:0]   lock_cnt,
    input  logic [ALPHA_W-1:0] alpha_acq,
    input  logic [ALPHA_W-1:0] alpha_trk,
    input  logic [BETA_W-1:0]  beta_acq,
    input  logic [BETA_W-1:0]  beta_trk
);

    state_t           st_q;
    state_t           st_nx;
    logic [TMR_W-1:0] timer_q;
    logic [TMR_W-1:0] per_lim;
    logic [TMR_W-1:0] acq_lim;
    logic             run_hit;
    logic             run_clear;
    logic             tracking;
    ctrl_out_t        ctrl_q;
    logic             unlock_q;

    assign tracking  = (st_q == S_TRACK);
    // The run only survives within one ACQ or TRACK stay.
    assign run_clear = (st_nx != st_q) || !(st_q == S_ACQ || tracking);

    err_run_cnt #(.LCK_W(LCK_W)) u_run (
        .clk      (clk),
        .rst      (rst),
        .clear    (run_clear),
        .mode     (tracking ? RUN_ABOVE : RUN_BELOW),
        .thr      (tracking ? unlock_thr : lock_thr),
        .lock_cnt (lock_cnt),
        .dpd_out  (bus.dpd_out),
        .hit      (run_hit)
    );

    // Next-state decision; abort overrides every other transition.
    always_comb begin
        st_nx   = st_q;
        per_lim = (per_settle == '0) ? '0 : per_settle - 1'b1;
        acq_lim = (acq_timeout == '0) ? '0 : acq_timeout - 1'b1;
        case (st_q)
            S_IDLE:    if (bus.start) st_nx = S_LOAD;
            S_LOAD:    st_nx = S_PER_CAL;
            S_PER_CAL: if (timer_q == per_lim) st_nx = S_ACQ;
            S_ACQ: begin
                // Lock takes precedence over a coincident timeout.
                if (run_hit)
                    st_nx = S_TRACK;
                else if (timer_q == acq_lim)
                    st_nx = S_FAIL;
            end
            S_TRACK:   if (run_hit) st_nx = S_ACQ;
            S_FAIL:    if (bus.start) st_nx = S_LOAD;
            default:   st_nx = S_IDLE;
        endcase
        if (bus.abort)
            st_nx = S_IDLE;
    end

    // State, dwell timer and registered outputs for the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q     <= S_IDLE;
            timer_q  <= '0;
            ctrl_q   <= CTRL_RST;
            unlock_q <= 1'b0;
        end else begin
            st_q <= st_nx;
            if (st_nx != st_q || !(st_q == S_PER_CAL || st_q == S_ACQ))
                timer_q <= '0;
            else
                timer_q <= timer_q + 1'b1;
            ctrl_q   <= outs_for(st_nx, alpha_acq, alpha_trk, beta_acq, beta_trk);
            unlock_q <= tracking && (st_nx == S_ACQ);
        end
    end

    assign bus.state      = st_q;
    assign bus.rst_l_per  = ctrl_q.rst_l_per;
    assign bus.rst_l_dpd  = ctrl_q.rst_l_dpd;
    assign bus.openLoop   = ctrl_q.open_loop;
    assign bus.alpha      = ctrl_q.alpha;
    assign bus.beta       = ctrl_q.beta;
    assign bus.locked     = ctrl_q.locked;
    assign bus.fail       = ctrl_q.fail;
    assign bus.unlock_evt = unlock_q;

endmodule

// File: tb/tb_loop_seq_ctrl.sv
// Self-checking bench for loop_seq_ctrl: per-cycle expected states are queued
// as stimulus is applied and compared against the DUT after each edge.
module tb_loop_seq_ctrl;
    import loop_ctrl_pkg::*;

    localparam int TMR_W = 16;
    localparam int LCK_W = 8;

    localparam logic [2:0] A_ACQ = 3'd2;
    localparam logic [2:0] A_TRK = 3'd5;
    localparam logic [3:0] B_ACQ = 4'd3;
    localparam logic [3:0] B_TRK = 4'd9;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [TMR_W-1:0] per_settle  = 16'd4;
    logic [TMR_W-1:0] acq_timeout = 16'd20;
    logic [17:0]      lock_thr    = 18'd100;
    logic [17:0]      unlock_thr  = 18'd1000;
    logic [LCK_W-1:0] lock_cnt    = 8'd3;
    logic [2:0]       alpha_acq   = A_ACQ;
    logic [2:0]       alpha_trk   = A_TRK;
    logic [3:0]       beta_acq    = B_ACQ;
    logic [3:0]       beta_trk    = B_TRK;

    loop_seq_ctrl_if bus ();

    loop_seq_ctrl #(.TMR_W(TMR_W), .LCK_W(LCK_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .per_settle  (per_settle),
        .acq_timeout (acq_timeout),
        .lock_thr    (lock_thr),
        .unlock_thr  (unlock_thr),
        .lock_cnt    (lock_cnt),
        .alpha_acq   (alpha_acq),
        .alpha_trk   (alpha_trk),
        .beta_acq    (beta_acq),
        .beta_trk    (beta_trk)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [2:0] st;
        logic       unl;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Expected flags {rst_l_per,rst_l_dpd,openLoop,alpha,beta,locked,fail}.
    function automatic logic [31:0] exp_flags(input logic [2:0] st);
        case (st)
            3'd2:    return {18'd0, 1'b0, 1'b1, 1'b1, A_ACQ, B_ACQ, 1'b0, 1'b0};
            3'd3:    return {18'd0, 1'b1, 1'b0, 1'b0, A_ACQ, B_ACQ, 1'b0, 1'b0};
            3'd4:    return {18'd0, 1'b1, 1'b0, 1'b0, A_TRK, B_TRK, 1'b1, 1'b0};
            3'd5:    return {18'd0, 1'b0, 1'b1, 1'b1, A_ACQ, B_ACQ, 1'b0, 1'b1};
            default: return {18'd0, 1'b1, 1'b1, 1'b1, A_ACQ, B_ACQ, 1'b0, 1'b0};
        endcase
    endfunction

    function automatic logic [31:0] act_flags();
        return {18'd0, bus.rst_l_per, bus.rst_l_dpd, bus.openLoop, bus.alpha,
                bus.beta, bus.locked, bus.fail};
    endfunction

    task automatic push(input string tag, input logic [2:0] st, input logic unl = 1'b0);
        exp_t e;
        e.tag = tag;
        e.st  = st;
        e.unl = unl;
        sb.push_back(e);
    endtask

    // One clock; outputs are compared on the falling edge against the queue.
    task automatic step();
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({e.tag, ".state"}, 32'(bus.state), 32'(e.st));
            check({e.tag, ".outs"},  act_flags(),    exp_flags(e.st));
            check({e.tag, ".unlock"}, 32'(bus.unlock_evt), 32'(e.unl));
        end
    endtask

    task automatic drain();
        while (sb.size() != 0) step();
    endtask

    // Start request followed by LOAD and n_per PER_CAL cycles.
    task automatic start_seq(input string tag, input int n_per);
        bus.start = 1'b1;
        push({tag, ".load"}, 3'd1);
        step();
        bus.start = 1'b0;
        for (int i = 0; i < n_per; i++) push({tag, ".percal"}, 3'd2);
        drain();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".state"}, 32'(bus.state), 32'd0);
        check({tag, ".outs"}, act_flags(),
              {18'd0, 1'b1, 1'b1, 1'b1, 3'd0, 4'd0, 1'b0, 1'b0});
        check({tag, ".unlock"}, 32'(bus.unlock_evt), 32'd0);
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.dpd_out = 19'sd50;

        // Reset values while reset is asserted.
        #1 rst = 1'b0;
        #2 check_reset_vals("rst");
        @(negedge clk);
        rst = 1'b1;

        // First edge after release loads IDLE values.
        push("idle0", 3'd0);
        step();

        // start and abort together: abort wins.
        bus.start = 1'b1;
        bus.abort = 1'b1;
        push("start_abort", 3'd0);
        step();
        bus.start = 1'b0;
        bus.abort = 1'b0;

        // Basic acquisition: LOAD 1, PER_CAL 4, ACQ 3, then TRACK.
        start_seq("acq", 4);
        for (int i = 0; i < 3; i++) push("acq.acq", 3'd3);
        push("acq.track", 3'd4);
        drain();

        // Loss of lock in TRACK: 3 cycles of |e| >= unlock_thr.
        bus.dpd_out = -19'sd2000;
        push("unl.trk", 3'd4);
        push("unl.trk", 3'd4);
        push("unl.evt", 3'd3, 1'b1);
        drain();
        bus.dpd_out = 19'sd50;
        push("relock.acq", 3'd3);
        push("relock.acq", 3'd3);
        push("relock.track", 3'd4);
        drain();

        // Abort from TRACK.
        bus.abort = 1'b1;
        push("abort_trk", 3'd0);
        step();
        bus.abort = 1'b0;

        // Alternating error never builds a run; timeout after 20 ACQ cycles.
        start_seq("tmo", 4);
        for (int i = 0; i < 20; i++) begin
            bus.dpd_out = (i % 2 == 0) ? 19'sd50 : 19'sd500;
            push("tmo.acq", 3'd3);
            step();
        end
        push("tmo.fail", 3'd5);
        step();
        push("tmo.hold", 3'd5);
        step();

        // Most negative error saturates and stays above the largest threshold.
        lock_thr    = 18'd262143;
        lock_cnt    = 8'd1;
        acq_timeout = 16'd5;
        bus.dpd_out = -19'sd262144;
        start_seq("sat", 4);
        for (int i = 0; i < 5; i++) push("sat.acq", 3'd3);
        push("sat.fail", 3'd5);
        drain();

        // Lock and timeout in the same cycle: lock wins. per_settle=0 acts as 1.
        lock_thr    = 18'd100;
        lock_cnt    = 8'd3;
        acq_timeout = 16'd3;
        per_settle  = 16'd0;
        bus.dpd_out = 19'sd50;
        start_seq("tie", 1);
        for (int i = 0; i < 2; i++) push("tie.acq", 3'd3);
        push("tie.acq_last", 3'd3);
        push("tie.track", 3'd4);
        drain();

        // Back to IDLE, re-acquire, ignore start in ACQ, then async reset.
        bus.abort = 1'b1;
        push("abort2", 3'd0);
        step();
        bus.abort   = 1'b0;
        acq_timeout = 16'd100;
        bus.dpd_out = 19'sd500;
        start_seq("ign", 1);
        push("ign.acq", 3'd3);
        step();
        bus.start = 1'b1;
        push("ign.start", 3'd3);
        step();
        bus.start = 1'b0;
        #2 rst = 1'b0;
        #1 check_reset_vals("async_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
